uv_mb_scheduler: RTL and testbench
==================================

# uv_mb_scheduler

Macroblock-level sequencer for the chroma mode-decision engine. It walks a frame in raster order, requests the source and neighbour data for each macroblock, issues one start pulse per macroblock to the UV pick-best datapath, and drives its `x`/`y` coordinates. It then waits for that block's done and hands the result to the writeback path over a valid/ready handshake. It sits between the frame controller and the UV pick-best datapath.

## Interface
Parameters:
- `XW`, 10, width of MB coordinate and dimension fields
- `CW`, 20, width of the completed-MB counter

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock domain, asynchronous assert, active-low
- `frame_start`  in  1  single-cycle request to process one frame
- `mb_w`  in  XW  frame width in MBs; sampled on accepted `frame_start`
- `mb_h`  in  XW  frame height in MBs; sampled on accepted `frame_start`
- `src_req`  out  1  request to load source/top/left/top-left for current MB
- `src_ack`  in  1  load complete
- `pick_start`  out  1  one-cycle start to the UV datapath
- `pick_x`  out  XW  current MB column
- `pick_y`  out  XW  current MB row
- `pick_done`  in  1  datapath done pulse
- `res_valid`  out  1  datapath outputs (out/levels/mode_uv/nz) valid for writeback
- `res_ready`  in  1  writeback accepts result
- `busy`  out  1  high from accepted `frame_start` until `frame_done`
- `frame_done`  out  1  one-cycle pulse at end of frame
- `mb_count`  out  CW  MBs completed in current/last frame

## Operation
- States: IDLE, LOAD, START, RUN, WRITE, NEXT, FIN.
- IDLE: on `frame_start`, latch `mb_w`/`mb_h`, clear `pick_x`, `pick_y` and `mb_count`.
  - Both dims non-zero: go to LOAD.
  - Either dim zero: go to FIN (no MB processed).
- LOAD: `src_req`=1. Sampling `src_ack`=1 moves to START.
- START: `pick_start`=1 for exactly this cycle, then go to RUN.
- RUN: wait for `pick_done`, then go to WRITE.
- WRITE: `res_valid`=1. Sampling `res_ready`=1 moves to NEXT.
- NEXT: `mb_count`+1.
  - `pick_x`==w-1: `pick_x`←0 and `pick_y`+1.
  - Otherwise: `pick_x`+1.
  - If this was the last MB (x==w-1 and y==h-1), go to FIN; otherwise go to LOAD.
  - On the last MB, coordinates are left at (w-1,h-1).
- FIN: `frame_done`=1 for one cycle, then go to IDLE.
- `busy` = (state != IDLE).
- `pick_x`/`pick_y` change only in IDLE (clear) and NEXT. They are stable from LOAD through WRITE, as the datapath and its diffusion-error store read `x` throughout.
- Ignored inputs:
  - `frame_start` outside IDLE
  - `src_ack` outside LOAD
  - `pick_done` outside RUN
  - `res_ready` outside WRITE
- `pick_done` and `res_ready` arriving in the same cycle: only `pick_done` acts (RUN→WRITE). `res_ready` must be sampled again in WRITE.
- Dimension inputs are not re-read mid-frame.

## Timing
- All outputs are registered or decoded directly from the state register; no combinational input→output path.
- Reset values: state IDLE; all outputs 0 (`pick_x`, `pick_y`, `mb_count` = 0).
- Reset mid-frame returns to IDLE immediately (asynchronous); outputs are 0 in the same instant. The next `frame_start` is served normally.
- `frame_start` at cycle 0 gives `src_req`=1 and `busy`=1 at cycle 1.
- `src_ack` sampled at cycle n gives `pick_start` at n+1.
- `pick_done` at cycle m gives `res_valid` at m+1.
- `res_ready` at cycle k gives NEXT at k+1. The next `src_req` (or `frame_done`) follows at k+2.
- Minimum MB period with zero-wait responders and `pick_done` one cycle after start: 5 cycles.
- Two consecutive `pick_start` pulses are always at least 4 cycles apart. This leaves the datapath's one-cycle DONE→IDLE return and the diffusion-error store start clear of the next start.

## Test plan
- 2×2 frame, `src_ack`/`res_ready` tied 1, `pick_done` 3 cycles after each start:
  - `pick_start` occurs 4 times, with (x,y) = (0,0),(1,0),(0,1),(1,1).
  - One `frame_done`, with `mb_count`=4.
  - `busy` falls the cycle after `frame_done`.
- 3×1 and 1×3 frames: (x,y) sequences are (0,0),(1,0),(2,0) and (0,0),(0,1),(0,2) respectively. Final coordinates (2,0) and (0,2). `mb_count`=3.
- `mb_w`=0, `mb_h`=5 with `frame_start`: `frame_done` occurs 1 cycle later, no `src_req` or `pick_start`, `mb_count`=0.
- Backpressure:
  - Hold `res_ready`=0 for 6 cycles in WRITE: `res_valid` stays 1, `pick_x`/`pick_y` are unchanged, and there is no `src_req`.
  - Assert `res_ready` in the same cycle as `pick_done`: no advance until `res_ready` is sampled in WRITE.
- `frame_start` pulsed in RUN with different `mb_w`/`mb_h`: ignored; the frame completes with the original dims. Stray `pick_done` during LOAD is ignored, so no `pick_start` is skipped.
- `rst_n` low during RUN of MB (1,0) in a 2×2 frame: all outputs go to 0 immediately. After release, a new `frame_start` restarts at (0,0) and completes with `mb_count`=4.

Source files
------------

// File: rtl/uv_mb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uv_mb_scheduler
// Description : Raster-order macroblock sequencer for the chroma mode-decision
//               engine: load request, datapath start, result handoff per MB.
// Revision    : 1.0 - initial release
// ============================================================================
module uv_mb_scheduler #(
    parameter int XW = 10,
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic [XW-1:0] mb_w,
    input  logic [XW-1:0] mb_h,
    output logic          src_req,
    input  logic          src_ack,
    output logic          pick_start,
    output logic [XW-1:0] pick_x,
    output logic [XW-1:0] pick_y,
    input  logic          pick_done,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic          frame_done,
    output logic [CW-1:0] mb_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_WRITE = 3'd4,
        ST_NEXT  = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] w_q, w_d;
    logic [XW-1:0] h_q, h_d;
    logic [XW-1:0] x_q, x_d;
    logic [XW-1:0] y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_col;
    logic          last_row;

    assign last_col = (x_q == w_q - XW'(1));
    assign last_row = (y_q == h_q - XW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    w_d   = mb_w;
                    h_d   = mb_h;
                    x_d   = '0;
                    y_d   = '0;
                    cnt_d = '0;
                    // An empty frame still reports completion through FIN.
                    state_d = ((mb_w == '0) || (mb_h == '0)) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (src_ack) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (pick_done) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (res_ready) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                cnt_d = cnt_q + CW'(1);
                if (last_col) begin
                    // Last MB keeps its coordinates at (w-1, h-1).
                    if (last_row) begin
                        state_d = ST_FIN;
                    end else begin
                        x_d     = '0;
                        y_d     = y_q + XW'(1);
                        state_d = ST_LOAD;
                    end
                end else begin
                    x_d     = x_q + XW'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign src_req    = (state_q == ST_LOAD);
    assign pick_start = (state_q == ST_START);
    assign res_valid  = (state_q == ST_WRITE);
    assign frame_done = (state_q == ST_FIN);
    assign busy       = (state_q != ST_IDLE);
    assign pick_x     = x_q;
    assign pick_y     = y_q;
    assign mb_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uv_mb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uv_mb_scheduler
// Description : Randomised bench for uv_mb_scheduler against a frame-level
//               reference model, plus directed frame scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uv_mb_scheduler;
    localparam int XW = 10;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [XW-1:0] mb_w = '0;
    logic [XW-1:0] mb_h = '0;
    logic          src_ack = 1'b0;
    logic          pick_done = 1'b0;
    logic          res_ready = 1'b0;
    logic          src_req, pick_start, res_valid, busy, frame_done;
    logic [XW-1:0] pick_x, pick_y;
    logic [CW-1:0] mb_count;

    uv_mb_scheduler #(.XW(XW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .mb_w(mb_w), .mb_h(mb_h), .src_req(src_req), .src_ack(src_ack),
        .pick_start(pick_start), .pick_x(pick_x), .pick_y(pick_y),
        .pick_done(pick_done), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .frame_done(frame_done), .mb_count(mb_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Responders: random acceptance, or a fixed start-to-done delay.
    int p_ack = 100, p_rdy = 100, p_done = 0, dly = 3, dd = 0;
    bit stray_done = 1'b0, rdy_with_done = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        src_ack   = ($urandom_range(99) < p_ack);
        pick_done = 1'b0;
        if (dly > 0) begin
            if (pick_start === 1'b1) dd = dly;
            else if (dd > 0) begin
                pick_done = (dd == 1);
                dd--;
            end
        end else begin
            pick_done = ($urandom_range(99) < p_done);
        end
        if (stray_done && src_req === 1'b1) pick_done = 1'b1;
        res_ready = rdy_with_done ? pick_done : ($urandom_range(99) < p_rdy);
    end

    // Reference model: phase of the current MB, linear MB index k, and the
    // raster coordinates derived from k by division.
    int m_ph = 0, m_k = 0, m_w = 0, m_h = 0, m_x = 0, m_y = 0, m_cnt = 0;
    longint cyc_n = 0, last_start = -100;
    int sx[$], sy[$];
    int n_done = 0, n_srcreq = 0;

    initial forever begin
        @(negedge clk);
        cyc_n++;
        if (!rst_n) begin
            m_ph = 0; m_x = 0; m_y = 0; m_cnt = 0; last_start = -100;
        end
        check("src_req",    32'(src_req),    32'(m_ph == 1));
        check("pick_start", 32'(pick_start), 32'(m_ph == 2));
        check("res_valid",  32'(res_valid),  32'(m_ph == 4));
        check("frame_done", 32'(frame_done), 32'(m_ph == 6));
        check("busy",       32'(busy),       32'(m_ph != 0));
        check("pick_x",     32'(pick_x),     m_x);
        check("pick_y",     32'(pick_y),     m_y);
        check("mb_count",   32'(mb_count),   m_cnt);
        if (pick_start === 1'b1) begin
            check("start_gap_ge4", 32'(cyc_n - last_start >= 4), 32'd1);
            last_start = cyc_n;
            sx.push_back(int'(pick_x));
            sy.push_back(int'(pick_y));
        end
        if (frame_done === 1'b1) n_done++;
        if (src_req === 1'b1) n_srcreq++;
        if (rst_n) begin
            case (m_ph)
                0: if (frame_start) begin
                    m_w = int'(mb_w); m_h = int'(mb_h);
                    m_k = 0; m_x = 0; m_y = 0; m_cnt = 0;
                    m_ph = (m_w == 0 || m_h == 0) ? 6 : 1;
                end
                1: if (src_ack) m_ph = 2;
                2: m_ph = 3;
                3: if (pick_done) m_ph = 4;
                4: if (res_ready) m_ph = 5;
                5: begin
                    m_cnt++;
                    if (m_k == m_w * m_h - 1) m_ph = 6;
                    else begin
                        m_k++;
                        m_x = m_k % m_w;
                        m_y = m_k / m_w;
                        m_ph = 1;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame(input int w, input int h);
        mb_w = XW'(w);
        mb_h = XW'(h);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget, input int p_fs);
        int c = 0;
        while (frame_done !== 1'b1 && c < budget) begin
            if (p_fs > 0 && $urandom_range(99) < p_fs) begin
                frame_start = 1'b1;
                mb_w = XW'($urandom_range(7));
                mb_h = XW'($urandom_range(7));
            end
            cyc();
            frame_start = 1'b0;
            c++;
        end
        check({nm, "_frame_done_seen"}, 32'(frame_done), 32'd1);
    endtask

    task automatic check_seq(input string nm, input int ex[4], input int ey[4], input int n);
        check({nm, "_nstarts"}, sx.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < sx.size()) begin
                check($sformatf("%s_x%0d", nm, i), sx[i], ex[i]);
                check($sformatf("%s_y%0d", nm, i), sy[i], ey[i]);
            end
        end
    endtask

    int ex[4], ey[4];
    int c, w, h;

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_busy",  32'(busy), 0);
        check("rst_x",     32'(pick_x), 0);
        check("rst_count", 32'(mb_count), 0);

        // 2x2, tied acks, done three cycles after start
        sx.delete(); sy.delete(); n_done = 0;
        start_frame(2, 2);
        check("t1_src_req_c1", 32'(src_req), 1);
        check("t1_busy_c1",    32'(busy), 1);
        wait_done("t1", 200, 0);
        check("t1_count", 32'(mb_count), 4);
        check("t1_fx",    32'(pick_x), 1);
        check("t1_fy",    32'(pick_y), 1);
        cyc();
        check("t1_busy_after", 32'(busy), 0);
        check("t1_ndone", n_done, 1);
        ex = '{0, 1, 0, 1}; ey = '{0, 0, 1, 1};
        check_seq("t1", ex, ey, 4);

        // 3x1
        sx.delete(); sy.delete();
        start_frame(3, 1);
        wait_done("t2", 200, 0);
        check("t2_count", 32'(mb_count), 3);
        check("t2_fx", 32'(pick_x), 2);
        check("t2_fy", 32'(pick_y), 0);
        cyc();
        ex = '{0, 1, 2, 0}; ey = '{0, 0, 0, 0};
        check_seq("t2", ex, ey, 3);

        // 1x3
        sx.delete(); sy.delete();
        start_frame(1, 3);
        wait_done("t3", 200, 0);
        check("t3_count", 32'(mb_count), 3);
        check("t3_fx", 32'(pick_x), 0);
        check("t3_fy", 32'(pick_y), 2);
        cyc();
        ex = '{0, 0, 0, 0}; ey = '{0, 1, 2, 0};
        check_seq("t3", ex, ey, 3);

        // zero-width frame
        sx.delete(); sy.delete(); n_srcreq = 0;
        start_frame(0, 5);
        check("t4_done_c1",  32'(frame_done), 1);
        check("t4_count",    32'(mb_count), 0);
        check("t4_src_req",  32'(src_req), 0);
        cyc();
        check("t4_busy_after", 32'(busy), 0);
        check("t4_nsrcreq", n_srcreq, 0);
        check("t4_nstarts", sx.size(), 0);

        // backpressure in WRITE, then ready coincident with done
        p_rdy = 0;
        start_frame(2, 2);
        c = 0;
        while (res_valid !== 1'b1 && c < 50) begin cyc(); c++; end
        check("t5_wait_valid", 32'(res_valid), 1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("t5_hold_valid", 32'(res_valid), 1);
            check("t5_hold_x", 32'(pick_x), 0);
            check("t5_hold_y", 32'(pick_y), 0);
            check("t5_no_src_req", 32'(src_req), 0);
        end
        p_rdy = 100;
        cyc();
        p_rdy = 0;
        rdy_with_done = 1'b1;
        c = 0;
        while (pick_done !== 1'b1 && c < 50) begin cyc(); c++; end
        check("t5_wait_done", 32'(pick_done), 1);
        cyc();
        check("t5_same_valid", 32'(res_valid), 1);
        check("t5_same_x", 32'(pick_x), 1);
        cyc();
        check("t5_same_still_valid", 32'(res_valid), 1);
        check("t5_same_no_src_req", 32'(src_req), 0);
        rdy_with_done = 1'b0;
        p_rdy = 100;
        wait_done("t5", 200, 0);
        check("t5_count", 32'(mb_count), 4);
        cyc();

        // frame_start ignored in RUN; stray done during LOAD
        sx.delete(); sy.delete();
        p_ack = 50; stray_done = 1'b1;
        start_frame(2, 2);
        c = 0;
        while (pick_start !== 1'b1 && c < 100) begin cyc(); c++; end
        check("t6_wait_start", 32'(pick_start), 1);
        cyc();
        mb_w = XW'(3); mb_h = XW'(3); frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        wait_done("t6", 500, 0);
        check("t6_count", 32'(mb_count), 4);
        cyc();
        ex = '{0, 1, 0, 1}; ey = '{0, 0, 1, 1};
        check_seq("t6", ex, ey, 4);
        p_ack = 100; stray_done = 1'b0;

        // asynchronous reset during RUN of MB (1,0)
        start_frame(2, 2);
        c = 0;
        while (!(pick_start === 1'b1 && pick_x == 1 && pick_y == 0) && c < 100) begin cyc(); c++; end
        check("t7_wait_mb10", 32'(pick_start), 1);
        cyc();
        #1 rst_n = 1'b0;
        #1;
        check("t7_rst_busy",   32'(busy), 0);
        check("t7_rst_srcreq", 32'(src_req), 0);
        check("t7_rst_start",  32'(pick_start), 0);
        check("t7_rst_valid",  32'(res_valid), 0);
        check("t7_rst_fdone",  32'(frame_done), 0);
        check("t7_rst_x",      32'(pick_x), 0);
        check("t7_rst_count",  32'(mb_count), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        sx.delete(); sy.delete();
        start_frame(2, 2);
        wait_done("t7", 200, 0);
        check("t7_count", 32'(mb_count), 4);
        cyc();
        ex = '{0, 1, 0, 1}; ey = '{0, 0, 1, 1};
        check_seq("t7", ex, ey, 4);

        // randomised frames and responders with stray frame_start pulses
        dly = 0;
        for (int f = 0; f < 30; f++) begin
            p_ack  = $urandom_range(100, 20);
            p_done = $urandom_range(100, 10);
            p_rdy  = $urandom_range(100, 20);
            w = $urandom_range(4);
            h = $urandom_range(4);
            start_frame(w, h);
            wait_done("rnd", 3000, 5);
            check("rnd_count", 32'(mb_count), w * h);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
